// File: rtl/pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pcie_tx_arbiter
//   Shares the 64-bit PCIe TX AXI stream between three TLP sources:
//   register-read completions (CplD), DMA write requests (MWr32) and DMA read
//   requests (MRd32). Builds 3-DW headers, sequences payload beats and holds
//   the presented beat stable under tready back-pressure.
//
// Parameters
//   WR_LEN_DW  MWr payload length in DW (even, 2..1022)
//   RD_LEN_DW  MRd requested length in DW (1..1023)
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_completer_id            bus/dev/fn used as requester/completer ID
//   i_cpl_req / o_cpl_ack     completion request, acked on header beat
//   i_cpl_rid_tag             {requester ID, tag} of the read being answered
//   i_cpl_address             QW address of that read
//   i_cpl_data                64-bit read data, low DW first
//   i_wr_req / o_wr_ack       DMA write request, acked on last beat
//   i_wr_addr, i_wr_data      write address and FWFT payload word
//   o_wr_data_ren             pops one payload word
//   i_rd_req / o_rd_ack       DMA read request, acked on header beat
//   i_rd_addr, i_rd_tag       read address and tag
//   o_tx_*, i_tx_tready       AXI stream towards the PCIe core
// ---------------------------------------------------------------------------
module pcie_tx_arbiter #(
  parameter int WR_LEN_DW = 32,
  parameter int RD_LEN_DW = 128
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_completer_id,
  input  logic        i_cpl_req,
  input  logic [23:0] i_cpl_rid_tag,
  input  logic [12:0] i_cpl_address,
  input  logic [63:0] i_cpl_data,
  output logic        o_cpl_ack,
  input  logic        i_wr_req,
  input  logic [31:0] i_wr_addr,
  input  logic [63:0] i_wr_data,
  output logic        o_wr_data_ren,
  output logic        o_wr_ack,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic [7:0]  i_rd_tag,
  output logic        o_rd_ack,
  output logic        o_tx_tvalid,
  input  logic        i_tx_tready,
  output logic        o_tx_tlast,
  output logic [7:0]  o_tx_tkeep,
  output logic [63:0] o_tx_tdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CPL0,
    S_CPL1,
    S_CPL2,
    S_WR0,
    S_WR_BODY,
    S_WR_LAST,
    S_RD0,
    S_RD1
  } state_t;

  localparam logic [8:0] LAST_WORD  = 9'(WR_LEN_DW / 2 - 1);
  localparam logic [9:0] WR_LEN     = 10'(WR_LEN_DW);
  localparam logic [9:0] RD_LEN     = 10'(RD_LEN_DW);
  localparam logic [3:0] RD_LAST_BE = (RD_LEN_DW == 1) ? 4'h0 : 4'hF;

  localparam logic [6:0] FT_CPLD  = 7'b1001010;
  localparam logic [6:0] FT_MWR32 = 7'b1000000;
  localparam logic [6:0] FT_MRD32 = 7'b0000000;

  // Host memory is little-endian: byte 0 of each DW goes to the top lane.
  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  state_t      r_state, w_next_state;
  logic        r_tvalid, w_tvalid_n;
  logic        r_tlast, w_tlast_n;
  logic [7:0]  r_tkeep, w_tkeep_n;
  logic [63:0] r_tdata, w_tdata_n;
  logic [63:0] r_hold, w_hold_n;       // image of beat 1 (DW2 plus first data DW)
  logic [31:0] r_hold_dw, w_hold_dw_n; // CplD second data DW
  logic        r_rr_wr, w_rr_wr_n;     // 1: MWr wins a WR/RD tie
  logic [8:0]  r_cnt, w_cnt_n;         // MWr payload words popped so far
  logic        w_accept;

  // Header DWs
  logic [31:0] w_cpl_dw0, w_cpl_dw1, w_cpl_dw2;
  logic [31:0] w_wr_dw0, w_wr_dw1, w_wr_dw2;
  logic [31:0] w_rd_dw0, w_rd_dw1, w_rd_dw2;

  assign w_cpl_dw0 = {1'b0, FT_CPLD, 14'd0, 10'd2};
  assign w_cpl_dw1 = {i_completer_id, 3'b000, 1'b0, 12'd8};
  assign w_cpl_dw2 = {i_cpl_rid_tag, 1'b0, i_cpl_address[3:0], 3'b000};
  assign w_wr_dw0  = {1'b0, FT_MWR32, 14'd0, WR_LEN};
  assign w_wr_dw1  = {i_completer_id, 8'h00, 4'hF, 4'hF};
  assign w_wr_dw2  = {i_wr_addr[31:2], 2'b00};
  assign w_rd_dw0  = {1'b0, FT_MRD32, 14'd0, RD_LEN};
  assign w_rd_dw1  = {i_completer_id, i_rd_tag, RD_LAST_BE, 4'hF};
  assign w_rd_dw2  = {i_rd_addr[31:2], 2'b00};

  logic w_unused;
  assign w_unused = ^{i_cpl_address[12:4]};

  assign w_accept = r_tvalid && i_tx_tready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    w_next_state  = r_state;
    w_tvalid_n    = r_tvalid;
    w_tlast_n     = r_tlast;
    w_tkeep_n     = r_tkeep;
    w_tdata_n     = r_tdata;
    w_hold_n      = r_hold;
    w_hold_dw_n   = r_hold_dw;
    w_rr_wr_n     = r_rr_wr;
    w_cnt_n       = r_cnt;
    o_cpl_ack     = 1'b0;
    o_wr_ack      = 1'b0;
    o_rd_ack      = 1'b0;
    o_wr_data_ren = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_cpl_req) begin
          w_next_state = S_CPL0;
          w_tvalid_n   = 1'b1;
          w_tlast_n    = 1'b0;
          w_tkeep_n    = 8'hFF;
          w_tdata_n    = {w_cpl_dw1, w_cpl_dw0};
          // Data is captured at grant: the source may move on after the ack.
          w_hold_n     = {swap_bytes(i_cpl_data[31:0]), w_cpl_dw2};
          w_hold_dw_n  = swap_bytes(i_cpl_data[63:32]);
        end else if (i_wr_req && (r_rr_wr || !i_rd_req)) begin
          w_next_state = S_WR0;
          w_tvalid_n   = 1'b1;
          w_tlast_n    = 1'b0;
          w_tkeep_n    = 8'hFF;
          w_tdata_n    = {w_wr_dw1, w_wr_dw0};
          w_hold_n     = {32'd0, w_wr_dw2};
          w_rr_wr_n    = 1'b0;
          w_cnt_n      = '0;
        end else if (i_rd_req) begin
          w_next_state = S_RD0;
          w_tvalid_n   = 1'b1;
          w_tlast_n    = 1'b0;
          w_tkeep_n    = 8'hFF;
          w_tdata_n    = {w_rd_dw1, w_rd_dw0};
          w_hold_n     = {32'd0, w_rd_dw2};
          w_rr_wr_n    = 1'b1;
        end
      end

      S_CPL0: if (w_accept) begin
        o_cpl_ack    = 1'b1;
        w_next_state = S_CPL1;
        w_tdata_n    = r_hold;
      end

      S_CPL1: if (w_accept) begin
        w_next_state = S_CPL2;
        w_tdata_n    = {32'd0, r_hold_dw};
        w_tkeep_n    = 8'h0F;
        w_tlast_n    = 1'b1;
      end

      S_WR0: if (w_accept) begin
        w_next_state = S_WR_BODY;
        w_tdata_n    = {32'd0, r_hold[31:0]};
      end

      // Body beats take their upper DW straight from the FWFT word; the lower
      // DW is the upper half of the previously popped word.
      S_WR_BODY: if (w_accept) begin
        o_wr_data_ren = 1'b1;
        w_tdata_n     = {32'd0, swap_bytes(i_wr_data[63:32])};
        if (r_cnt == LAST_WORD) begin
          w_next_state = S_WR_LAST;
          w_tkeep_n    = 8'h0F;
          w_tlast_n    = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 9'd1;
        end
      end

      S_RD0: if (w_accept) begin
        o_rd_ack     = 1'b1;
        w_next_state = S_RD1;
        w_tdata_n    = r_hold;
        w_tkeep_n    = 8'h0F;
        w_tlast_n    = 1'b1;
      end

      S_CPL2, S_WR_LAST, S_RD1: if (w_accept) begin
        o_wr_ack     = (r_state == S_WR_LAST);
        w_next_state = S_IDLE;
        w_tvalid_n   = 1'b0;
        w_tlast_n    = 1'b0;
        w_tkeep_n    = 8'hFF;
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tkeep   <= 8'hFF;
      r_tdata   <= '0;
      r_hold    <= '0;
      r_hold_dw <= '0;
      r_rr_wr   <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next_state;
      r_tvalid  <= w_tvalid_n;
      r_tlast   <= w_tlast_n;
      r_tkeep   <= w_tkeep_n;
      r_tdata   <= w_tdata_n;
      r_hold    <= w_hold_n;
      r_hold_dw <= w_hold_dw_n;
      r_rr_wr   <= w_rr_wr_n;
      r_cnt     <= w_cnt_n;
    end
  end

  assign o_tx_tvalid = r_tvalid;
  assign o_tx_tlast  = r_tlast;
  assign o_tx_tkeep  = r_tkeep;
  assign o_tx_tdata  = (r_state == S_WR_BODY)
                     ? {swap_bytes(i_wr_data[31:0]), r_tdata[31:0]}
                     : r_tdata;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pcie_tx_arbiter
//   Directed self-checking bench for pcie_tx_arbiter: CplD/MWr/MRd contents,
//   arbitration order, back-pressure hold and reset abort.
// ---------------------------------------------------------------------------
module tb_pcie_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_completer_id;
  logic        i_cpl_req;
  logic [23:0] i_cpl_rid_tag;
  logic [12:0] i_cpl_address;
  logic [63:0] i_cpl_data;
  logic        o_cpl_ack;
  logic        i_wr_req;
  logic [31:0] i_wr_addr;
  logic [63:0] i_wr_data;
  logic        o_wr_data_ren;
  logic        o_wr_ack;
  logic        i_rd_req;
  logic [31:0] i_rd_addr;
  logic [7:0]  i_rd_tag;
  logic        o_rd_ack;
  logic        o_tx_tvalid;
  logic        i_tx_tready;
  logic        o_tx_tlast;
  logic [7:0]  o_tx_tkeep;
  logic [63:0] o_tx_tdata;

  pcie_tx_arbiter #(.WR_LEN_DW(32), .RD_LEN_DW(128)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_completer_id (i_completer_id),
    .i_cpl_req      (i_cpl_req),
    .i_cpl_rid_tag  (i_cpl_rid_tag),
    .i_cpl_address  (i_cpl_address),
    .i_cpl_data     (i_cpl_data),
    .o_cpl_ack      (o_cpl_ack),
    .i_wr_req       (i_wr_req),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .o_wr_data_ren  (o_wr_data_ren),
    .o_wr_ack       (o_wr_ack),
    .i_rd_req       (i_rd_req),
    .i_rd_addr      (i_rd_addr),
    .i_rd_tag       (i_rd_tag),
    .o_rd_ack       (o_rd_ack),
    .o_tx_tvalid    (o_tx_tvalid),
    .i_tx_tready    (i_tx_tready),
    .o_tx_tlast     (o_tx_tlast),
    .o_tx_tkeep     (o_tx_tkeep),
    .o_tx_tdata     (o_tx_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Payload FIFO model: word k presented until popped.
  logic [63:0] fifo [32];
  int          pop_idx;

  // Captured TLP
  logic [63:0] cap_data [64];
  logic [7:0]  cap_keep [64];
  logic        cap_last [64];
  int cap_n, n_pops, n_cpl_ack, n_wr_ack, n_rd_ack;
  int cpl_ack_at, wr_ack_at, rd_ack_at;

  function automatic logic [31:0] bs(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_fifo_head();
    i_wr_data = (pop_idx < 32) ? fifo[pop_idx] : 64'd0;
  endtask

  // Collect one TLP. mode 0: tready always 1; 1: tready toggles;
  // 2: tready held low 100 cycles while beat 1 is presented.
  task automatic get_tlp(input int mode);
    int  cyc = 0;
    int  stall = 0;
    bit  done = 0;
    bit  acc;
    bit  held_v = 0;
    logic [63:0] held_d = '0;
    cap_n = 0; n_pops = 0; n_cpl_ack = 0; n_wr_ack = 0; n_rd_ack = 0;
    cpl_ack_at = -1; wr_ack_at = -1; rd_ack_at = -1;
    i_tx_tready = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      acc = o_tx_tvalid && i_tx_tready;
      if (held_v && o_tx_tvalid) check("hold_tdata", o_tx_tdata, held_d);
      held_v = o_tx_tvalid && !i_tx_tready;
      held_d = o_tx_tdata;
      if (o_wr_data_ren) begin
        n_pops++;
        check("ren_only_on_accept", 64'(acc), 64'd1);
      end
      if (o_cpl_ack) begin n_cpl_ack++; cpl_ack_at = cap_n; end
      if (o_wr_ack)  begin n_wr_ack++;  wr_ack_at  = cap_n; end
      if (o_rd_ack)  begin n_rd_ack++;  rd_ack_at  = cap_n; end
      if (acc && cap_n < 64) begin
        cap_data[cap_n] = o_tx_tdata;
        cap_keep[cap_n] = o_tx_tkeep;
        cap_last[cap_n] = o_tx_tlast;
        cap_n++;
        if (o_tx_tlast) done = 1;
      end
      @(posedge clk);
      #1;
      if (o_cpl_ack === 1'b0 && n_cpl_ack > 0) i_cpl_req = 1'b0;
      if (n_wr_ack > 0) i_wr_req = 1'b0;
      if (n_rd_ack > 0) i_rd_req = 1'b0;
      pop_idx = n_pops;
      load_fifo_head();
      case (mode)
        1:       i_tx_tready = ~i_tx_tready;
        2:       if (cap_n == 1 && stall < 100) begin i_tx_tready = 1'b0; stall++; end
                 else i_tx_tready = 1'b1;
        default: i_tx_tready = 1'b1;
      endcase
      cyc++;
    end
    if (n_cpl_ack > 0) i_cpl_req = 1'b0;
    check("tlp_complete_in_budget", 64'(done), 64'd1);
  endtask

  task automatic check_cpld();
    check("cpl_beats", 64'(cap_n), 64'd3);
    check("cpl_beat0", cap_data[0], 64'hABCD0008_4A000002);
    check("cpl_beat1", cap_data[1], 64'h88776655_0102A518);
    check("cpl_beat2_lo", 64'(cap_data[2][31:0]), 64'h44332211);
    check("cpl_keep0", 64'(cap_keep[0]), 64'hFF);
    check("cpl_keep2", 64'(cap_keep[2]), 64'h0F);
    check("cpl_last1", 64'(cap_last[1]), 64'd0);
    check("cpl_last2", 64'(cap_last[2]), 64'd1);
    check("cpl_ack_count", 64'(n_cpl_ack), 64'd1);
    check("cpl_ack_beat", 64'(cpl_ack_at), 64'd0);
    check("cpl_no_pops", 64'(n_pops), 64'd0);
  endtask

  task automatic check_mwr(input logic [31:0] addr);
    check("mwr_beats", 64'(cap_n), 64'd18);
    check("mwr_beat0", cap_data[0], 64'hABCD00FF_40000020);
    check("mwr_beat1", cap_data[1], {bs(fifo[0][31:0]), addr});
    for (int k = 2; k <= 16; k++)
      check($sformatf("mwr_beat%0d", k), cap_data[k],
            {bs(fifo[k-1][31:0]), bs(fifo[k-2][63:32])});
    check("mwr_beat17_lo", 64'(cap_data[17][31:0]), 64'(bs(fifo[15][63:32])));
    check("mwr_keep16", 64'(cap_keep[16]), 64'hFF);
    check("mwr_keep17", 64'(cap_keep[17]), 64'h0F);
    check("mwr_last16", 64'(cap_last[16]), 64'd0);
    check("mwr_last17", 64'(cap_last[17]), 64'd1);
    check("mwr_pops", 64'(n_pops), 64'd16);
    check("mwr_ack_count", 64'(n_wr_ack), 64'd1);
    check("mwr_ack_beat", 64'(wr_ack_at), 64'd17);
  endtask

  task automatic start_wr(input logic [31:0] addr);
    pop_idx   = 0;
    load_fifo_head();
    i_wr_addr = addr;
    i_wr_req  = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    for (int k = 0; k < 32; k++)
      fifo[k] = {16'hA000 + 16'(k), 16'hB100 + 16'(k), 16'hC200 + 16'(k), 16'hD300 + 16'(k)};
    rst_n = 1'b0;
    i_completer_id = 16'hABCD;
    i_cpl_req = 1'b0; i_cpl_rid_tag = 24'h0102A5; i_cpl_address = 13'h0003;
    i_cpl_data = 64'h11223344_55667788;
    i_wr_req = 1'b0; i_wr_addr = 32'h0000_1000; pop_idx = 0; load_fifo_head();
    i_rd_req = 1'b0; i_rd_addr = 32'h8000_0040; i_rd_tag = 8'h07;
    i_tx_tready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(o_tx_tvalid), 64'd0);
    check("rst_tlast", 64'(o_tx_tlast), 64'd0);
    check("rst_tkeep", 64'(o_tx_tkeep), 64'hFF);
    check("rst_tdata", o_tx_tdata, 64'd0);
    check("rst_acks_ren", 64'({o_cpl_ack, o_wr_ack, o_rd_ack, o_wr_data_ren}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CplD, tready always high; first beat one cycle after grant
    i_cpl_req = 1'b1;
    @(negedge clk);
    check("cpl_not_before_grant", 64'(o_tx_tvalid), 64'd0);
    get_tlp(0);
    check_cpld();

    // All three requests together: CplD, then MWr, then MRd
    i_cpl_req = 1'b1; start_wr(32'h0000_1000); i_rd_req = 1'b1;
    get_tlp(0);
    check("arb1_is_cpl", 64'(cap_data[0][31:0]), 64'h4A000002);
    get_tlp(0);
    check("arb2_is_mwr", 64'(cap_data[0][31:0]), 64'h40000020);
    check_mwr(32'h0000_1000);
    get_tlp(0);
    check("arb3_is_mrd", 64'(cap_data[0][31:0]), 64'h00000080);

    // Both persisting: grants alternate WR, RD, WR
    start_wr(32'h0000_1000); i_rd_req = 1'b1;
    get_tlp(0);
    check("alt1_is_mwr", 64'(cap_data[0][31:0]), 64'h40000020);
    start_wr(32'h0000_1000);
    get_tlp(0);
    check("alt2_is_mrd", 64'(cap_data[0][31:0]), 64'h00000080);
    get_tlp(0);
    check("alt3_is_mwr", 64'(cap_data[0][31:0]), 64'h40000020);

    // MWr with tready toggling
    start_wr(32'h0000_1000);
    get_tlp(1);
    check_mwr(32'h0000_1000);

    // MRd
    i_rd_req = 1'b1;
    get_tlp(0);
    check("mrd_beats", 64'(cap_n), 64'd2);
    check("mrd_beat0", cap_data[0], 64'hABCD07FF_00000080);
    check("mrd_beat1_lo", 64'(cap_data[1][31:0]), 64'h80000040);
    check("mrd_keep1", 64'(cap_keep[1]), 64'h0F);
    check("mrd_last1", 64'(cap_last[1]), 64'd1);
    check("mrd_ack_count", 64'(n_rd_ack), 64'd1);
    check("mrd_ack_beat", 64'(rd_ack_at), 64'd0);

    // CplD with 100-cycle stall on beat 1
    i_cpl_req = 1'b1;
    get_tlp(2);
    check_cpld();

    // Reset during MWr beat 5 aborts; next grant restarts at beat 0
    start_wr(32'h0000_2000);
    i_tx_tready = 1'b1;
    nacc = 0;
    for (int c = 0; c < 60 && nacc < 5; c++) begin
      @(negedge clk);
      if (o_tx_tvalid && i_tx_tready) nacc++;
      if (o_wr_data_ren) pop_idx++;
      @(posedge clk); #1;
      load_fifo_head();
    end
    check("abort_reached_beat5", 64'(nacc), 64'd5);
    check("abort_valid_before", 64'(o_tx_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_tvalid_low", 64'(o_tx_tvalid), 64'd0);
    check("abort_tdata_zero", o_tx_tdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_wr(32'h0000_2000);
    get_tlp(0);
    check("restart_beat0", cap_data[0], 64'hABCD00FF_40000020);
    check_mwr(32'h0000_2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
